seg_display_driver: RTL
=======================

Name: seg_display_driver

Overview:
- Output-side counterpart to the power-button input handler: takes the debounced `power_on` level and per-digit display codes, and drives the 8-digit multiplexed seven-segment display.
- Runs a lamp-test on power-up, then time-multiplexes the 8 digits with per-digit blanking, blinking and decimal point.
- Blanks the display entirely while powered off.
- Sits between the control FSM and the board pins.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz).
- BLINK_DIV, 25000000, clk cycles per blink-phase toggle (2 Hz blink).
- TEST_CYCLES, 50000000, lamp-test duration in clk cycles (0.5 s).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- power_on  in  1  power state level from the input handler; 1 = on.
- digits  in  32  eight 4-bit codes; digits[4i+3:4i] is digit i (digit 0 rightmost).
- blank_mask  in  8  bit i = 1 forces digit i dark.
- blink_mask  in  8  bit i = 1 makes digit i dark during the blink-off phase.
- dp_mask  in  8  bit i = 1 lights the decimal point of digit i.
- an  out  8  digit enables, active-high, one-hot or all-zero.
- seg  out  8  segments, active-high; seg[0]=a … seg[6]=g, seg[7]=dp.

Behaviour:
- Reset: asynchronous, active-high; clock clk.
  - Outputs: an=0, seg=0.
  - Counters: all counters 0, digit index 0.
  - State and phase: state=OFF, blink phase=on.
- FSM states: OFF, LAMP_TEST, RUN.
  - OFF: an=0, seg=0; scan and blink counters held at 0. When power_on=1 is sampled → LAMP_TEST, test counter cleared.
  - LAMP_TEST: every digit is scanned with seg=8'hFF; masks are ignored. The test counter increments each cycle. When it reaches TEST_CYCLES-1 → RUN, digit index and blink counter cleared.
  - RUN: normal scan, described below.
  - From LAMP_TEST or RUN, power_on=0 → OFF on the next edge; outputs are 0 from that edge.
  - power_on re-asserted during any state restarts from OFF rules; a short off pulse still reruns the lamp-test.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1; at terminal count the digit index increments mod 8 (7→0 wraps).
  - `an` is registered: an = 1<<index, updated on the same edge as the index.
  - `seg` is registered from the same index value.
  - Zero-cycle skew between `an` and `seg`; one-cycle latency from an input change to the pins.
- Digit content (RUN):
  - Start from decode(code) | (dp_mask[i]<<7).
  - Force seg=0 if blank_mask[i]=1, or if blink_mask[i]=1 and the blink phase is off.
  - `an` still asserts for a blanked digit, so scan timing stays uniform.
- Blink: the counter counts 0..BLINK_DIV-1 and toggles the phase at terminal count. It runs only in RUN and restarts with the on-phase on entry to RUN.
- Decode (gfedcba, hex):
  - 0..9 → 3F 06 5B 4F 66 6D 7D 07 7F 6F
  - 10 '-' → 40
  - 11 'H' → 76
  - 12 'L' → 38
  - 13 'P' → 73
  - 14 'E' → 79
  - 15 blank → 00
- Inputs are sampled directly; callers drive them synchronous to clk. power_on comes from a clk-domain register.
- Counter widths use $clog2 of each parameter. Parameters must be ≥ 2.

Decomposition:
- Shared package seg_pkg holds:
  - state encoding (OFF=2'd0, LAMP_TEST=2'd1, RUN=2'd2);
  - code constants (CODE_DASH=10, CODE_H=11, CODE_L=12, CODE_P=13, CODE_E=14, CODE_BLANK=15);
  - the 16-entry segment pattern constants.
- One sub-module, seg_decoder: combinational 4-bit code → 7-bit pattern. All sequencing stays in seg_display_driver.

Test Plan:
- Bench parameters: SCAN_DIV=4, BLINK_DIV=16, TEST_CYCLES=32.
- Reset asserted mid-RUN → an=0, seg=0 immediately (asynchronous) and held while reset=1; after release with power_on=0, outputs stay 0.
- power_on 0→1 → for 32 cycles seg=FF, with `an` stepping 01,02,04… every 4 cycles; then RUN.
- RUN scan: digits=32'h76543210, dp_mask=8'h04.
  - an=01 gives seg=3F; an=02 gives 06; an=04 gives DB (dp set); an=80 gives 07.
  - After an=80 the next slot returns to an=01.
- Masks: blank_mask=8'h01 → seg=00 while an=01. blink_mask=8'h02 → digit 1 shows 06 for 16 cycles, then 00 for 16 cycles, alternating.
- Codes 10..15 on digit 0 → seg = 40, 76, 38, 73, 79, 00 respectively.
- power_on drops during LAMP_TEST at cycle 10 → an=0, seg=0 one edge later. Re-asserting it reruns the full 32-cycle lamp-test.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display driver.
// Segment patterns are gfedcba, active-high.
package seg_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    LAMP_TEST = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_H     = 4'd11;
  localparam logic [3:0] CODE_L     = 4'd12;
  localparam logic [3:0] CODE_P     = 4'd13;
  localparam logic [3:0] CODE_E     = 4'd14;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  localparam logic [6:0] SEG_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h76,
    7'h38, 7'h73, 7'h79, 7'h00
  };

endpackage

// File: rtl/seg_display_driver_seg_decoder.sv
// Combinational display-code to segment-pattern lookup.
// Pattern bit 0 is segment a, bit 6 is segment g.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  assign pattern = SEG_PAT[code];

endmodule

// File: rtl/seg_display_driver.sv
// Multiplexed 8-digit seven-segment driver with power-up lamp test,
// per-digit blanking, blinking and decimal point.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_DIV   = 25000000,
  parameter int TEST_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        power_on,
  input  logic [31:0] digits,
  input  logic [7:0]  blank_mask,
  input  logic [7:0]  blink_mask,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int TW = $clog2(TEST_CYCLES);

  state_t          state, state_n;
  logic [SW-1:0]   scnt, scnt_n;
  logic [BW-1:0]   bcnt, bcnt_n;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic [2:0]      idx, idx_n;
  logic            phase, phase_n;
  logic            scan_tc, blink_tc, test_done;
  logic [3:0]      code;
  logic [6:0]      pat;
  logic [7:0]      run_seg, an_n, seg_n;

  assign scan_tc   = scnt == SW'(SCAN_DIV - 1);
  assign blink_tc  = bcnt == BW'(BLINK_DIV - 1);
  assign test_done = tcnt == TW'(TEST_CYCLES - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= OFF;
      scnt  <= '0;
      bcnt  <= '0;
      tcnt  <= '0;
      idx   <= '0;
      phase <= 1'b1;
      an    <= '0;
      seg   <= '0;
    end else begin
      state <= state_n;
      scnt  <= scnt_n;
      bcnt  <= bcnt_n;
      tcnt  <= tcnt_n;
      idx   <= idx_n;
      phase <= phase_n;
      an    <= an_n;
      seg   <= seg_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      OFF:       if (power_on) state_n = LAMP_TEST;
      LAMP_TEST: begin
        if (!power_on)      state_n = OFF;
        else if (test_done) state_n = RUN;
      end
      RUN:       if (!power_on) state_n = OFF;
      default:   state_n = OFF;
    endcase
  end

  // Every state change clears the counters; they only advance while
  // the FSM stays put in an active state.
  always_comb begin
    scnt_n  = '0;
    idx_n   = '0;
    bcnt_n  = '0;
    tcnt_n  = '0;
    phase_n = 1'b1;
    if (state_n == state && state != OFF) begin
      scnt_n = scan_tc ? '0 : scnt + 1'b1;
      idx_n  = scan_tc ? idx + 3'd1 : idx;
    end
    if (state == LAMP_TEST && state_n == LAMP_TEST)
      tcnt_n = tcnt + 1'b1;
    if (state == RUN && state_n == RUN) begin
      bcnt_n  = blink_tc ? '0 : bcnt + 1'b1;
      phase_n = blink_tc ? ~phase : phase;
    end
  end

  assign code = digits[{idx_n, 2'b00} +: 4];

  seg_decoder u_dec (
    .code    (code),
    .pattern (pat)
  );

  always_comb begin
    run_seg = {dp_mask[idx_n], pat};
    if (blank_mask[idx_n] || (blink_mask[idx_n] && !phase_n))
      run_seg = '0;
    an_n  = (state_n == OFF) ? 8'h00 : 8'h01 << idx_n;
    seg_n = '0;
    unique case (state_n)
      LAMP_TEST: seg_n = 8'hFF;
      RUN:       seg_n = run_seg;
      default:   seg_n = '0;
    endcase
  end

endmodule
